// File: rtl/traffic_timer.sv
// Two-road countdown timer: a shared one-second prescaler drives per-road counters
// that reload on each lamp phase change. Optional freeze input enabled by TRAFFIC_TIMER_HOLD_EN.
module traffic_timer #(
  parameter int TICK_DIV = 4,
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 2,
  parameter int RED_T    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rstc,
  input  logic [2:0] signal1,
  input  logic [2:0] signal2,
  output logic       zero1,
  output logic       zero2,
  output logic [7:0] count1,
  output logic [7:0] count2,
  output logic       tick
`ifdef TRAFFIC_TIMER_HOLD_EN
  ,
  input  logic       hold
`endif
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_prescaler;
  logic [7:0]    r_count1;
  logic [7:0]    r_count2;
  logic [2:0]    r_sigPrev1;
  logic [2:0]    r_sigPrev2;

  logic       w_hold;
  logic       w_tick;
  logic       w_load1;
  logic       w_load2;
  logic [7:0] w_dur1;
  logic [7:0] w_dur2;

  // Only a clean one-hot lamp state has a duration; dark or conflicting lamps give 0.
  function automatic logic [7:0] phaseDuration(input logic [2:0] sig);
    case (sig)
      3'b001:  return 8'(GREEN_T);
      3'b010:  return 8'(YELLOW_T);
      3'b100:  return 8'(RED_T);
      default: return 8'd0;
    endcase
  endfunction

`ifdef TRAFFIC_TIMER_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_tick  = !rst && !w_hold && (r_prescaler == PRE_MAX);
  assign w_load1 = rstc || (signal1 != r_sigPrev1);
  assign w_load2 = rstc || (signal2 != r_sigPrev2);
  assign w_dur1  = phaseDuration(signal1);
  assign w_dur2  = phaseDuration(signal2);

  assign tick   = w_tick;
  assign count1 = r_count1;
  assign count2 = r_count2;
  assign zero1  = rst || (r_count1 == 8'd0);
  assign zero2  = rst || (r_count2 == 8'd0);

  // A reload restarts the second so the first tick lands a full TICK_DIV cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescaler <= '0;
    end else if (rstc) begin
      r_prescaler <= '0;
    end else if (!w_hold) begin
      r_prescaler <= (r_prescaler == PRE_MAX) ? '0 : r_prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count1   <= 8'd0;
      r_count2   <= 8'd0;
      r_sigPrev1 <= 3'b000;
      r_sigPrev2 <= 3'b000;
    end else begin
      r_sigPrev1 <= signal1;
      r_sigPrev2 <= signal2;
      if (w_load1) begin
        r_count1 <= w_dur1;
      end else if (w_tick && (r_count1 != 8'd0)) begin
        r_count1 <= r_count1 - 8'd1;
      end
      if (w_load2) begin
        r_count2 <= w_dur2;
      end else if (w_tick && (r_count2 != 8'd0)) begin
        r_count2 <= r_count2 - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_timer.sv
// Scoreboard bench for traffic_timer: a behavioural model queues the expected outputs per cycle,
// plus directed checks for reset, countdown, saturation, phase change, tick collision and hold.
module tb_traffic_timer;

  localparam int TICK_DIV = 4;
  localparam int GREEN_T  = 5;
  localparam int YELLOW_T = 2;
  localparam int RED_T    = 7;

  logic       clk;
  logic       rst;
  logic       rstc;
  logic [2:0] signal1;
  logic [2:0] signal2;
  logic       holdDrv;
  logic       zero1;
  logic       zero2;
  logic [7:0] count1;
  logic [7:0] count2;
  logic       tick;

  int checkCount = 0;
  int failCount  = 0;

  int         mPre;
  int         mCnt1;
  int         mCnt2;
  logic [2:0] mPrev1;
  logic [2:0] mPrev2;
  logic [18:0] expQ[$];

  traffic_timer #(
    .TICK_DIV(TICK_DIV),
    .GREEN_T (GREEN_T),
    .YELLOW_T(YELLOW_T),
    .RED_T   (RED_T)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rstc   (rstc),
    .signal1(signal1),
    .signal2(signal2),
    .zero1  (zero1),
    .zero2  (zero2),
    .count1 (count1),
    .count2 (count2),
    .tick   (tick)
`ifdef TRAFFIC_TIMER_HOLD_EN
    ,
    .hold   (holdDrv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int durOf(input logic [2:0] sig);
    if (sig == 3'b001) return GREEN_T;
    if (sig == 3'b010) return YELLOW_T;
    if (sig == 3'b100) return RED_T;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, then compare after the edge.
  task automatic applyStimulus(input logic r, input logic rc, input logic [2:0] s1,
                               input logic [2:0] s2, input logic h);
    logic        mTick;
    logic [18:0] expVal;
    logic [18:0] gotVal;
    @(negedge clk);
    rst = r; rstc = rc; signal1 = s1; signal2 = s2; holdDrv = h;
    mTick = !r && !h && (mPre == TICK_DIV - 1);
    if (r) begin
      mPre = 0; mCnt1 = 0; mCnt2 = 0; mPrev1 = 3'b000; mPrev2 = 3'b000;
    end else begin
      if (rc || (s1 != mPrev1)) mCnt1 = durOf(s1);
      else if (mTick && mCnt1 > 0) mCnt1 = mCnt1 - 1;
      if (rc || (s2 != mPrev2)) mCnt2 = durOf(s2);
      else if (mTick && mCnt2 > 0) mCnt2 = mCnt2 - 1;
      if (rc) mPre = 0;
      else if (!h) mPre = (mPre + 1) % TICK_DIV;
      mPrev1 = s1;
      mPrev2 = s2;
    end
    expVal = {(!r && !h && (mPre == TICK_DIV - 1)), (r || mCnt1 == 0), (r || mCnt2 == 0),
              8'(mCnt1), 8'(mCnt2)};
    expQ.push_back(expVal);
    @(posedge clk);
    #1;
    gotVal = {tick, zero1, zero2, count1, count2};
    checkOutput("cycle", 32'(gotVal), 32'(expQ.pop_front()));
  endtask

  initial begin
    logic [2:0] r1;
    logic [2:0] r2;
    logic [2:0] pick [6];
    bit         seen;
    rst = 1'b1; rstc = 1'b0; signal1 = 3'b000; signal2 = 3'b000; holdDrv = 1'b0;
    mPre = 0; mCnt1 = 0; mCnt2 = 0; mPrev1 = 3'b000; mPrev2 = 3'b000;
    pick[0] = 3'b001; pick[1] = 3'b010; pick[2] = 3'b100;
    pick[3] = 3'b000; pick[4] = 3'b011; pick[5] = 3'b111;

    // Reset state
    applyStimulus(1'b1, 1'b0, 3'b001, 3'b100, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b001, 3'b100, 1'b0);
    checkOutput("rstCount1", 32'(count1), 32'd0);
    checkOutput("rstCount2", 32'(count2), 32'd0);
    checkOutput("rstZero1", 32'(zero1), 32'd1);
    checkOutput("rstZero2", 32'(zero2), 32'd1);
    checkOutput("rstTick", 32'(tick), 32'd0);

    // Countdown after a reload
    applyStimulus(1'b0, 1'b1, 3'b001, 3'b100, 1'b0);
    checkOutput("loadCount1", 32'(count1), 32'd5);
    checkOutput("loadCount2", 32'(count2), 32'd7);
    checkOutput("loadZero1", 32'(zero1), 32'd0);
    checkOutput("loadZero2", 32'(zero2), 32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 3'b001, 3'b100, 1'b0);
    checkOutput("expireZero1", 32'(zero1), 32'd1);
    checkOutput("expireCount2", 32'(count2), 32'd2);

    // Saturation at zero over three more ticks
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 3'b001, 3'b100, 1'b0);
    checkOutput("satCount1", 32'(count1), 32'd0);
    checkOutput("satZero1", 32'(zero1), 32'd1);

    // Phase change without rstc on each road in turn
    applyStimulus(1'b0, 1'b0, 3'b001, 3'b001, 1'b0);
    checkOutput("chgCount2", 32'(count2), 32'd5);
    applyStimulus(1'b0, 1'b0, 3'b010, 3'b001, 1'b0);
    checkOutput("chgCount1", 32'(count1), 32'd2);
    checkOutput("chgKeep2", 32'(count2), 32'd5);

    // rstc landing on a tick cycle
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      applyStimulus(1'b0, 1'b0, 3'b010, 3'b001, 1'b0);
      seen = (tick == 1'b1);
    end
    checkOutput("tickWait", 32'(seen), 32'd1);
    applyStimulus(1'b0, 1'b1, 3'b010, 3'b001, 1'b0);
    checkOutput("colCount1", 32'(count1), 32'd2);
    checkOutput("colCount2", 32'(count2), 32'd5);
    checkOutput("colTick", 32'(tick), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 3'b010, 3'b001, 1'b0);
    checkOutput("colTickDue", 32'(tick), 32'd1);
    checkOutput("colNoDecYet", 32'(count1), 32'd2);
    applyStimulus(1'b0, 1'b0, 3'b010, 3'b001, 1'b0);
    checkOutput("colDecAt4", 32'(count1), 32'd1);

    // Reset mid-countdown, then reload on release
    applyStimulus(1'b0, 1'b1, 3'b001, 3'b100, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 3'b001, 3'b100, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b010, 3'b010, 1'b0);
    checkOutput("abortCount1", 32'(count1), 32'd0);
    checkOutput("abortZero2", 32'(zero2), 32'd1);
    applyStimulus(1'b0, 1'b0, 3'b001, 3'b100, 1'b0);
    checkOutput("releaseCount1", 32'(count1), 32'd5);
    checkOutput("releaseCount2", 32'(count2), 32'd7);

`ifdef TRAFFIC_TIMER_HOLD_EN
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 3'b001, 3'b100, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 3'b001, 3'b100, 1'b1);
      checkOutput("holdTick", 32'(tick), 32'd0);
      checkOutput("holdCount1", 32'(count1), 32'd4);
    end
    applyStimulus(1'b0, 1'b1, 3'b001, 3'b100, 1'b1);
    checkOutput("holdReload1", 32'(count1), 32'd5);
    checkOutput("holdReload2", 32'(count2), 32'd7);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 3'b001, 3'b100, 1'b1);
    checkOutput("holdFrozen1", 32'(count1), 32'd5);
`endif

    // Random traffic checked against the model
    r1 = 3'b001;
    r2 = 3'b100;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) r1 = pick[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) r2 = pick[$urandom_range(0, 5)];
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), r1, r2,
`ifdef TRAFFIC_TIMER_HOLD_EN
                    ($urandom_range(0, 9) == 0)
`else
                    1'b0
`endif
                    );
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/traffic_timer.md
TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4: clk cycles per one-second tick, minimum 2.
REQ-002 SHALL have parameter GREEN_T, default 5: green phase duration, in ticks.
REQ-003 SHALL have parameter YELLOW_T, default 2: yellow phase duration, in ticks.
REQ-004 SHALL have parameter RED_T, default 7: red phase duration, in ticks, 1..255.
REQ-005 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port rstc  in  1  reload request from the controller.
REQ-008 SHALL have port signal1  in  3  road-1 lamp state: bit2 red, bit1 yellow, bit0 green.
REQ-009 SHALL have port signal2  in  3  road-2 lamp state, same encoding as signal1.
REQ-010 SHALL have port zero1  out  1  road-1 countdown expired.
REQ-011 SHALL have port zero2  out  1  road-2 countdown expired.
REQ-012 SHALL have port count1  out  8  road-1 remaining ticks, for display.
REQ-013 SHALL have port count2  out  8  road-2 remaining ticks, for display.
REQ-014 SHALL have port tick  out  1  one-cycle pulse per elapsed second.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-016 tick SHALL be combinational: tick = (prescaler == TICK_DIV-1).
REQ-017 Phase-to-duration map SHALL be: signal 001 -> GREEN_T, 010 -> YELLOW_T, 100 -> RED_T.
REQ-018 Any other signal value (000 or multi-hot) SHALL map to duration 0.
REQ-019 Channel n SHALL load its mapped duration at the next edge when rstc=1 or signaln differs from its registered previous value (sig_prevn).
REQ-020 sig_prevn SHALL capture signaln on every edge.
REQ-021 On an edge with tick=1 and no load, each channel SHALL decrement if its count > 0; a count of 0 SHALL hold (saturate, no wrap).
REQ-022 A load SHALL take priority over a decrement on the same edge; each channel is evaluated independently.
REQ-023 rstc=1 SHALL clear the prescaler to 0 on that edge; the first tick after a reload therefore arrives TICK_DIV cycles later.
REQ-024 zeron SHALL be combinational: zeron = (countn == 0).
REQ-025 Latency: a load is visible on countn and zeron one cycle after the rstc or signal change is sampled.
REQ-026 A signal change and rstc on the same edge SHALL produce a single load of the new duration.

Reset
REQ-027 While rst=1, the following SHALL hold at each edge: prescaler=0, count1=count2=0, sig_prev1=sig_prev2=000.
REQ-028 During reset the outputs SHALL be zero1=zero2=1 and tick=0.
REQ-029 rst SHALL override rstc, hold and all signal inputs.
REQ-030 Reset asserted mid-countdown SHALL abort the countdown at the next edge.
REQ-031 On the first edge after rst is released, a nonzero signaln SHALL be seen as a change and load its duration.

Configuration
REQ-032 With macro TRAFFIC_TIMER_HOLD_EN defined, the block SHALL add input port hold (1 bit).
REQ-033 With hold=1, the prescaler and both counters SHALL freeze and tick SHALL be forced to 0.
REQ-034 With hold=1, loads (rstc or signal change) SHALL still be honoured.
REQ-035 Without TRAFFIC_TIMER_HOLD_EN, the hold port SHALL be absent and the block SHALL behave as if hold=0.

Verification (TICK_DIV=4, GREEN_T=5, YELLOW_T=2, RED_T=7)
REQ-036 Reset: rst=1 for 2 cycles -> count1=count2=0, zero1=zero2=1, tick=0.
REQ-037 Countdown: signal1=001, signal2=100, rstc pulsed one cycle -> next edge count1=5, count2=7, zeros=0; after 5 ticks (20 cycles) zero1=1, count2=2.
REQ-038 Saturation: count1=0, 3 further ticks -> count1 stays 0, zero1 stays 1.
REQ-039 Signal change: signal1 001->010 with no rstc -> count1=2 one cycle later, count2 unchanged.
REQ-040 Collision: rstc coincides with tick=1 -> counts load rather than decrement, prescaler=0, next tick exactly 4 cycles later.
REQ-041 Hold (macro defined): hold=1 for 10 cycles mid-count -> counts frozen, tick=0; a rstc pulse during hold still reloads.
